// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_train_gen
//  Description : Multi-channel programmable pulse-train generator. A trigger
//                starts an optional delay followed by N high/low pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_train_gen #(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] trig_i,
    input  logic [CH-1:0] abort_i,
    input  logic [W-1:0]  cfg_delay_i,
    input  logic [W-1:0]  cfg_high_i,
    input  logic [W-1:0]  cfg_low_i,
    input  logic [W-1:0]  cfg_num_i,
    input  logic          retrig_en_i,
    output logic [CH-1:0] dout_o,
    output logic [CH-1:0] busy_o,
    output logic [CH-1:0] done_o
);

    localparam logic [W-1:0] C_ONE = W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HIGH  = 2'd2,
        ST_LOW   = 2'd3
    } state_t;

    // Zero-valued high/low/count fields behave as 1; shared by every channel.
    logic [W-1:0] w_high_eff;
    logic [W-1:0] w_low_eff;
    logic [W-1:0] w_num_eff;

    assign w_high_eff = (cfg_high_i == '0) ? C_ONE : cfg_high_i;
    assign w_low_eff  = (cfg_low_i  == '0) ? C_ONE : cfg_low_i;
    assign w_num_eff  = (cfg_num_i  == '0) ? C_ONE : cfg_num_i;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t       state_q, state_d;
        logic [W-1:0] cnt_q,   cnt_d;
        logic [W-1:0] pulse_q, pulse_d;
        logic [W-1:0] high_q,  high_d;
        logic [W-1:0] low_q,   low_d;
        logic [W-1:0] num_q,   num_d;
        logic         dout_q,  dout_d;
        logic         done_q,  done_d;
        logic         w_accept;

        assign w_accept = trig_i[g] & ((state_q == ST_IDLE) | retrig_en_i);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pulse_d = pulse_q;
            high_d  = high_q;
            low_d   = low_q;
            num_d   = num_q;
            done_d  = 1'b0;

            if (abort_i[g]) begin
                state_d = ST_IDLE;
            end else if (w_accept) begin
                high_d  = w_high_eff;
                low_d   = w_low_eff;
                num_d   = w_num_eff;
                pulse_d = '0;
                if (cfg_delay_i == '0) begin
                    state_d = ST_HIGH;
                    cnt_d   = w_high_eff - C_ONE;
                end else begin
                    state_d = ST_DELAY;
                    cnt_d   = cfg_delay_i - C_ONE;
                end
            end else begin
                // cnt_q holds the cycles remaining in the current state minus one.
                case (state_q)
                    ST_DELAY: begin
                        if (cnt_q == '0) begin
                            state_d = ST_HIGH;
                            cnt_d   = high_q - C_ONE;
                        end else begin
                            cnt_d = cnt_q - C_ONE;
                        end
                    end
                    ST_HIGH: begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - C_ONE;
                        end else if (pulse_q + C_ONE == num_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_LOW;
                            pulse_d = pulse_q + C_ONE;
                            cnt_d   = low_q - C_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (cnt_q == '0) begin
                            state_d = ST_HIGH;
                            cnt_d   = high_q - C_ONE;
                        end else begin
                            cnt_d = cnt_q - C_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            dout_d = (state_d == ST_HIGH);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pulse_q <= '0;
                high_q  <= '0;
                low_q   <= '0;
                num_q   <= '0;
                dout_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
                high_q  <= high_d;
                low_q   <= low_d;
                num_q   <= num_d;
                dout_q  <= dout_d;
                done_q  <= done_d;
            end
        end

        assign dout_o[g] = dout_q;
        assign busy_o[g] = (state_q != ST_IDLE);
        assign done_o[g] = done_q;
    end

endmodule
`default_nettype wire
